// File: rtl/dff_pkg.sv
// Shared defaults and parity helper for the dff register pipeline.
// Parity storage is present only when DFF_PARITY_EN is defined.
`timescale 1ns/1ps
package dff_pkg;

    localparam int unsigned DFF_DEFAULT_WIDTH = 1;
    localparam int unsigned DFF_DEFAULT_DEPTH = 1;

    // Widest data vector the parity helper accepts; callers zero-extend.
    localparam int unsigned DFF_MAX_WIDTH = 1024;

    // Even-parity bit: makes the total count of ones (data + bit) even.
    function automatic logic even_parity(input logic [DFF_MAX_WIDTH-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/dff_stage.sv
// One register stage of the dff pipeline: sync active-high reset, clock enable.
`timescale 1ns/1ps
module dff_stage #(
    parameter int unsigned     WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dff.sv
// Parameterizable D register pipeline (DEPTH stages, enable, sync reset).
// Define DFF_PARITY_EN to carry a parity bit per stage and expose par_err.
`timescale 1ns/1ps
module dff
    import dff_pkg::*;
#(
    parameter int unsigned      WIDTH       = DFF_DEFAULT_WIDTH,
    parameter int unsigned      DEPTH       = DFF_DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    output logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] qn
`ifdef DFF_PARITY_EN
    ,
    output logic             par_err
`endif
);

`ifdef DFF_PARITY_EN
    // Parity rides in the MSB of every stage so it shifts with its data.
    localparam int unsigned      STAGE_WIDTH = WIDTH + 1;
    localparam logic [WIDTH:0]   STAGE_RESET =
        {even_parity(DFF_MAX_WIDTH'(RESET_VALUE)), RESET_VALUE};
`else
    localparam int unsigned      STAGE_WIDTH = WIDTH;
    localparam logic [WIDTH-1:0] STAGE_RESET = RESET_VALUE;
`endif

    logic [STAGE_WIDTH-1:0] chain [DEPTH+1];

`ifdef DFF_PARITY_EN
    assign chain[0] = {even_parity(DFF_MAX_WIDTH'(d)), d};
`else
    assign chain[0] = d;
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        dff_stage #(
            .WIDTH       (STAGE_WIDTH),
            .RESET_VALUE (STAGE_RESET)
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .d   (chain[i]),
            .q   (chain[i+1])
        );
    end

    assign q  = chain[DEPTH][WIDTH-1:0];
    assign qn = ~q;

`ifdef DFF_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err <= 1'b0;
        end else begin
            par_err <= chain[DEPTH][WIDTH] != even_parity(DFF_MAX_WIDTH'(q));
        end
    end
`endif

endmodule

// File: tb/tb_dff.sv
// Directed self-checking bench for dff: a default 1-bit flop and an 8-bit, 3-deep pipeline.
`timescale 1ns/100ps
module tb_dff;

    logic       clk;
    logic       q1, d1, rst1, en1, qn1;
    logic [7:0] q8, d8, qn8;
    logic       rst8, en8;
`ifdef DFF_PARITY_EN
    logic       perr1, perr8;
`endif

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    dff dut_bit (
        .q   (q1),
        .d   (d1),
        .clk (clk),
        .rst (rst1),
        .en  (en1),
        .qn  (qn1)
`ifdef DFF_PARITY_EN
        , .par_err (perr1)
`endif
    );

    dff #(
        .WIDTH       (8),
        .DEPTH       (3),
        .RESET_VALUE (8'hA5)
    ) dut_pipe (
        .q   (q8),
        .d   (d8),
        .clk (clk),
        .rst (rst8),
        .en  (en8),
        .qn  (qn8)
`ifdef DFF_PARITY_EN
        , .par_err (perr8)
`endif
    );

    initial clk = 1'b0;
    always #3 clk = ~clk;

    initial begin
        #60000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        rst1 = 1'b1; en1 = 1'b1; d1 = 1'b1;
        rst8 = 1'b1; en8 = 1'b1; d8 = 8'hFF;
        @(posedge clk); #1;
        vectors++;
        if (q1 !== 1'b0 || qn1 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_bit: got q=%b qn=%b, required q=0 qn=1", q1, qn1);
        end
        vectors++;
        if (q8 !== 8'hA5 || qn8 !== 8'h5A) begin
            miscompares++;
            $display("FAIL reset_pipe: got q=%h qn=%h, required q=a5 qn=5a", q8, qn8);
        end
        // reset must win even with en low
        en8 = 1'b0; d8 = 8'h3C;
        @(posedge clk); #1;
        vectors++;
        if (q8 !== 8'hA5) begin
            miscompares++;
            $display("FAIL reset_en_low: got q=%h, required a5", q8);
        end
    endtask

    task automatic test_reset_priority();
        rst1 = 1'b1; en1 = 1'b1; d1 = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (q1 !== 1'b0 || qn1 !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_priority: got q=%b qn=%b, required q=0 qn=1", q1, qn1);
        end
        rst1 = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (q1 !== 1'b1 || qn1 !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_release: got q=%b qn=%b, required q=1 qn=0", q1, qn1);
        end
    endtask

    task automatic test_toggle();
        logic exp;
        rst1 = 1'b0; en1 = 1'b1; d1 = 1'b0;
        fork
            begin
                #4.5;
                for (int i = 0; i < 20; i++) begin
                    d1 = ~d1;
                    #5;
                end
            end
            begin
                for (int e = 0; e < 16; e++) begin
                    @(posedge clk);
                    exp = d1;
                    #1;
                    vectors++;
                    if (q1 !== exp || qn1 !== ~exp) begin
                        miscompares++;
                        $display("FAIL toggle_edge%0d: got q=%b qn=%b, required q=%b qn=%b",
                                 e, q1, qn1, exp, ~exp);
                    end
                    #3.5;
                    vectors++;
                    if (q1 !== exp) begin
                        miscompares++;
                        $display("FAIL toggle_hold%0d: got q=%b, required %b", e, q1, exp);
                    end
                end
            end
        join
    endtask

    task automatic test_enable_hold();
        rst1 = 1'b0; en1 = 1'b1; d1 = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (q1 !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_load: got q=%b, required 1", q1);
        end
        en1 = 1'b0; d1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (q1 !== 1'b1) begin
                miscompares++;
                $display("FAIL hold_edge%0d: got q=%b, required 1", i, q1);
            end
        end
        en1 = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (q1 !== 1'b0 || qn1 !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_release: got q=%b qn=%b, required q=0 qn=1", q1, qn1);
        end
    endtask

    task automatic test_pipeline_latency();
        logic [7:0] din [5];
        logic [7:0] qexp [5];
        din  = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00};
        qexp = '{8'hA5, 8'hA5, 8'h11, 8'h22, 8'h33};
        rst8 = 1'b1; en8 = 1'b1;
        @(posedge clk); #1;
        rst8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d8 = din[i];
            @(posedge clk); #1;
            vectors++;
            if (q8 !== qexp[i] || qn8 !== ~qexp[i]) begin
                miscompares++;
                $display("FAIL latency_edge%0d: got q=%h qn=%h, required q=%h qn=%h",
                         i + 1, q8, qn8, qexp[i], ~qexp[i]);
            end
`ifdef DFF_PARITY_EN
            vectors++;
            if (perr8 !== 1'b0) begin
                miscompares++;
                $display("FAIL latency_parerr%0d: got %b, required 0", i + 1, perr8);
            end
`endif
        end
    endtask

    task automatic test_en_gap();
        logic       ens  [8];
        logic [7:0] din  [8];
        logic [7:0] qexp [8];
        ens  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        din  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        qexp = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h01, 8'h01, 8'h03, 8'h05};
        rst8 = 1'b1; en8 = 1'b1;
        @(posedge clk); #1;
        rst8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            en8 = ens[i]; d8 = din[i];
            @(posedge clk); #1;
            vectors++;
            if (q8 !== qexp[i]) begin
                miscompares++;
                $display("FAIL en_gap_edge%0d: got q=%h, required %h", i + 1, q8, qexp[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [7:0] qexp [4];
        qexp = '{8'hA5, 8'hA5, 8'hA5, 8'h5A};
        rst8 = 1'b1; en8 = 1'b1;
        @(posedge clk); #1;
        rst8 = 1'b0;
        d8 = 8'hC1;
        @(posedge clk); #1;
        d8 = 8'hC2;
        @(posedge clk); #1;
        vectors++;
        if (q8 !== 8'hA5) begin
            miscompares++;
            $display("FAIL midstream_fill: got q=%h, required a5", q8);
        end
        rst8 = 1'b1; d8 = 8'hC3;
        @(posedge clk); #1;
        rst8 = 1'b0; d8 = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (q8 !== qexp[i]) begin
                miscompares++;
                $display("FAIL midstream_edge%0d: got q=%h, required %h", i, q8, qexp[i]);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (q8 !== 8'h5A) begin
            miscompares++;
            $display("FAIL midstream_final: got q=%h, required 5a", q8);
        end
    endtask

`ifdef DFF_PARITY_EN
    task automatic test_parity();
        logic [8:0] v;
        rst8 = 1'b1; en8 = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (perr8 !== 1'b0) begin
            miscompares++;
            $display("FAIL parity_reset: got %b, required 0", perr8);
        end
        rst8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d8 = 8'h3C + 8'(i * 7);
            @(posedge clk); #1;
            vectors++;
            if (perr8 !== 1'b0) begin
                miscompares++;
                $display("FAIL parity_traffic%0d: got %b, required 0", i, perr8);
            end
        end
        en8 = 1'b0;
        v = dut_pipe.g_stage[2].u_stage.q;
        v[0] = ~v[0];
        force dut_pipe.g_stage[2].u_stage.q = v;
        @(posedge clk); #1;
        vectors++;
        if (perr8 !== 1'b1) begin
            miscompares++;
            $display("FAIL parity_inject: got %b, required 1", perr8);
        end
        release dut_pipe.g_stage[2].u_stage.q;
        rst8 = 1'b1; en8 = 1'b1;
        @(posedge clk); #1;
        rst8 = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (perr8 !== 1'b0) begin
            miscompares++;
            $display("FAIL parity_after_reset: got %b, required 0", perr8);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_priority();
        test_toggle();
        test_enable_hold();
        test_pipeline_latency();
        test_en_gap();
        test_reset_midstream();
`ifdef DFF_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
